csr_access_unit: RTL and testbench

Sequencer that executes Zicsr instructions (CSRRW/S/C and immediate forms) against the machine CSR file. It accepts one decoded CSR request from the execute stage and drives the CSR file's read port and write port. It performs the read-modify-write in a fixed sequence and returns the old CSR value for register writeback. It also handles the CSR file's registered read port and its `freeze` read-hold behaviour.

---
 rtl/csr_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_csr_access_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// csr_access_unit: sequencer for Zicsr instructions (CSRRW/RS/RC and the
// immediate forms) against the machine CSR file. It takes one decoded request,
// reads the CSR through the file's registered read port, writes back the
// modified value with a one-cycle strobe, and returns the old value.
//
// Optional feature macro: CSR_RO_TRAP_EN
//   defined   -> a writing access to a read-only CSR (csr[11:10] == 2'b11)
//                is reported as illegal without touching the CSR file.
//   undefined -> no address check; the CSR file discards such writes itself.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   req_*             decoded CSR request from execute (valid/ready handshake)
//   flush             pipeline kill, aborts a request that has not committed
//   freeze            CSR file read-hold; while high csr_rddata does not update
//   csr_adr_rd        CSR file read address (csr_rddata valid one cycle later)
//   csr_adr_wr,
//   csr_wrdata,
//   csr_wr_en         CSR file write port, one-cycle strobe per write
//   rsp_*             old CSR value / destination / illegal flag to writeback
module csr_access_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [11:0]     req_csr,
  input  logic [4:0]      req_rs1_idx,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  input  logic            freeze,
  output logic [11:0]     csr_adr_rd,
  input  logic [XLEN-1:0] csr_rddata,
  output logic [11:0]     csr_adr_wr,
  output logic [XLEN-1:0] csr_wrdata,
  output logic            csr_wr_en,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [4:0]      rsp_rd,
  output logic            rsp_illegal
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RSP
  } state_t;

  state_t          state;

  // Latched request: funct3[1:0] selects RW/RS/RC, operand already resolved
  // to either rs1 value or zero-extended zimm.
  logic [1:0]      op_q;
  logic [XLEN-1:0] operand_q;
  logic            do_write_q;
  logic [XLEN-1:0] old_q;

  // Request decode, evaluated on the accepting cycle only.
  logic [XLEN-1:0] req_operand;
  logic            req_do_write;
  logic            req_illegal;

  // Modified CSR value formed from the freshly read data.
  logic [XLEN-1:0] cap_new;

  always_comb begin
    req_operand  = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_rs1_idx} : req_rs1_val;
    req_do_write = (req_funct3[1:0] == 2'b01) || (req_rs1_idx != 5'd0);
    req_illegal  = (req_funct3[1:0] == 2'b00);
`ifdef CSR_RO_TRAP_EN
    if (req_do_write && (req_csr[11:10] == 2'b11)) begin
      req_illegal = 1'b1;
    end
`endif
  end

  always_comb begin
    cap_new = '0;
    case (op_q)
      2'b01:   cap_new = operand_q;
      2'b10:   cap_new = csr_rddata | operand_q;
      default: cap_new = csr_rddata & ~operand_q;
    endcase
  end

  // csr_adr_rd doubles as the latched CSR address, so the read port sees it
  // in every state after acceptance and the write port copies it in CAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      csr_wr_en   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_illegal <= 1'b0;
      rsp_data    <= '0;
      rsp_rd      <= '0;
      csr_adr_rd  <= '0;
      csr_adr_wr  <= '0;
      csr_wrdata  <= '0;
      op_q        <= '0;
      operand_q   <= '0;
      do_write_q  <= 1'b0;
      old_q       <= '0;
    end else begin
      csr_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            csr_adr_rd <= req_csr;
            rsp_rd     <= req_rd;
            op_q       <= req_funct3[1:0];
            operand_q  <= req_operand;
            do_write_q <= req_do_write;
            req_ready  <= 1'b0;
            if (req_illegal) begin
              rsp_valid   <= 1'b1;
              rsp_illegal <= 1'b1;
              rsp_data    <= '0;
              state       <= RSP;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (flush) begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end else if (!freeze) begin
            state <= CAP;
          end
        end
        CAP: begin
          if (flush) begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            old_q <= csr_rddata;
            if (do_write_q) begin
              csr_wr_en  <= 1'b1;
              csr_adr_wr <= csr_adr_rd;
              csr_wrdata <= cap_new;
              state      <= WR;
            end else begin
              rsp_valid   <= 1'b1;
              rsp_illegal <= 1'b0;
              rsp_data    <= csr_rddata;
              state       <= RSP;
            end
          end
        end
        WR: begin
          // Write has committed this cycle; flush no longer applies.
          rsp_valid   <= 1'b1;
          rsp_illegal <= 1'b0;
          rsp_data    <= old_q;
          state       <= RSP;
        end
        RSP: begin
          if (flush || rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_illegal <= 1'b0;
            req_ready   <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid   <= 1'b0;
          rsp_illegal <= 1'b0;
          req_ready   <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
`timescale 1ns/1ps
module tb_csr_access_unit;

  localparam int XLEN  = 32;
  localparam int K_IDLE = 0;
  localparam int K_RD   = 1;
  localparam int K_CAP  = 2;
  localparam int K_WR   = 3;
  localparam int K_RSP  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [11:0] req_csr = '0;
  logic [4:0]  req_rs1_idx = '0;
  logic [31:0] req_rs1_val = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        freeze = 1'b0;
  logic        rsp_ready = 1'b1;
  logic [31:0] csr_rddata = '0;

  logic        req_ready;
  logic [11:0] csr_adr_rd;
  logic [11:0] csr_adr_wr;
  logic [31:0] csr_wrdata;
  logic        csr_wr_en;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_illegal;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  csr_access_unit #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funct3  (req_funct3),
    .req_csr     (req_csr),
    .req_rs1_idx (req_rs1_idx),
    .req_rs1_val (req_rs1_val),
    .req_rd      (req_rd),
    .flush       (flush),
    .freeze      (freeze),
    .csr_adr_rd  (csr_adr_rd),
    .csr_rddata  (csr_rddata),
    .csr_adr_wr  (csr_adr_wr),
    .csr_wrdata  (csr_wrdata),
    .csr_wr_en   (csr_wr_en),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_rd      (rsp_rd),
    .rsp_illegal (rsp_illegal)
  );

  // CSR addresses exercised and their reset contents.
  function automatic logic [11:0] addr_sel(input int i);
    case (i)
      0:       return 12'h300;
      1:       return 12'h305;
      2:       return 12'h340;
      3:       return 12'h344;
      4:       return 12'hF14;
      default: return 12'hC00;
    endcase
  endfunction

  function automatic logic [31:0] init_val(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_1888;
      12'h305: return 32'h0000_0100;
      12'h340: return 32'h0000_ABCD;
      12'h344: return 32'h0000_0088;
      12'hF14: return 32'h0000_0000;
      default: return 32'h1234_5678;
    endcase
  endfunction

  // Environment CSR file: registered read port with freeze hold; writes to
  // read-only addresses are discarded.
  logic [31:0] csr_mem [4096];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) csr_mem[addr_sel(i)] <= init_val(addr_sel(i));
    end else begin
      if (!freeze) csr_rddata <= csr_mem[csr_adr_rd];
      if (csr_wr_en && (csr_adr_wr[11:10] != 2'b11)) csr_mem[csr_adr_wr] <= csr_wrdata;
    end
  end

  // Reference model: architectural CSR contents plus a per-transaction
  // timeline (m_n = cycles since acceptance, m_r = cycle the read completed).
  logic [31:0] ref_mem [4096];
  bit          m_busy = 1'b0;
  bit          m_ill, m_dw;
  int          m_n, m_r;
  logic [11:0] m_addr;
  logic [31:0] m_old, m_new;
  logic [4:0]  m_rd;

  function automatic int kind();
    if (!m_busy) return K_IDLE;
    if (m_ill) return K_RSP;
    if (m_r == 0) return K_RD;
    if (m_n == m_r + 1) return K_CAP;
    if (m_dw && (m_n == m_r + 2)) return K_WR;
    return K_RSP;
  endfunction

  task automatic model_step();
    int          k;
    logic [31:0] operand;
    k = kind();
    if (rst) begin
      m_busy = 1'b0;
      for (int i = 0; i < 6; i++) ref_mem[addr_sel(i)] = init_val(addr_sel(i));
      return;
    end
    case (k)
      K_IDLE: begin
        if (req_valid && !flush) begin
          m_busy  = 1'b1;
          m_n     = 1;
          m_r     = 0;
          m_addr  = req_csr;
          m_rd    = req_rd;
          operand = req_funct3[2] ? {27'd0, req_rs1_idx} : req_rs1_val;
          m_ill   = (req_funct3[1:0] == 2'b00);
          m_dw    = (req_funct3[1:0] == 2'b01) || (req_rs1_idx != 5'd0);
`ifdef CSR_RO_TRAP_EN
          if (m_dw && (req_csr[11:10] == 2'b11)) m_ill = 1'b1;
`endif
          m_old = ref_mem[req_csr];
          case (req_funct3[1:0])
            2'b01:   m_new = operand;
            2'b10:   m_new = m_old | operand;
            default: m_new = m_old & ~operand;
          endcase
        end
      end
      K_RD: begin
        if (flush) m_busy = 1'b0;
        else begin
          if (!freeze) m_r = m_n;
          m_n++;
        end
      end
      K_CAP: begin
        if (flush) m_busy = 1'b0;
        else m_n++;
      end
      K_WR: begin
        if (m_addr[11:10] != 2'b11) ref_mem[m_addr] = m_new;
        m_n++;
      end
      default: begin
        if (flush || rsp_ready) m_busy = 1'b0;
        else m_n++;
      end
    endcase
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    int k;
    k = kind();
    cmp("req_ready", 32'(req_ready), 32'(k == K_IDLE));
    cmp("csr_wr_en", 32'(csr_wr_en), 32'(k == K_WR));
    if (k == K_WR) begin
      cmp("csr_adr_wr", 32'(csr_adr_wr), 32'(m_addr));
      cmp("csr_wrdata", csr_wrdata, m_new);
    end
    cmp("rsp_valid", 32'(rsp_valid), 32'(k == K_RSP));
    if (k == K_RSP) begin
      cmp("rsp_data", rsp_data, m_ill ? 32'd0 : m_old);
      cmp("rsp_rd", 32'(rsp_rd), 32'(m_rd));
      cmp("rsp_illegal", 32'(rsp_illegal), 32'(m_ill));
    end
    if ((k == K_RD) || (k == K_CAP)) cmp("csr_adr_rd", 32'(csr_adr_rd), 32'(m_addr));
  endtask

  always begin
    @(posedge clk);
    model_step();
    #1;
    if (chk_en) compare();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    cmp("wait_idle", 32'(req_ready), 32'd1);
  endtask

  // Presents a request for one accepting edge; returns in cycle 1.
  task automatic send(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                      input logic [31:0] v, input logic [4:0] rd);
    req_funct3  = f3;
    req_csr     = a;
    req_rs1_idx = idx;
    req_rs1_val = v;
    req_rd      = rd;
    req_valid   = 1'b1;
    tick();
    req_valid   = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) tick();
    cmp("rst_req_ready", 32'(req_ready), 32'd1);
    cmp("rst_wr_en", 32'(csr_wr_en), 32'd0);
    cmp("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    cmp("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
    cmp("rst_rsp_data", rsp_data, 32'd0);
    cmp("rst_rsp_rd", 32'(rsp_rd), 32'd0);
    cmp("rst_adr_rd", 32'(csr_adr_rd), 32'd0);
    cmp("rst_adr_wr", 32'(csr_adr_wr), 32'd0);
    cmp("rst_wrdata", csr_wrdata, 32'd0);
    rst = 1'b0;
    tick();

    // CSRRW mtvec
    wait_idle();
    send(3'b001, 12'h305, 5'd5, 32'h0000_1004, 5'd7);
    tick(); tick();
    cmp("t1_wr_en", 32'(csr_wr_en), 32'd1);
    cmp("t1_adr_wr", 32'(csr_adr_wr), 32'h305);
    cmp("t1_wrdata", csr_wrdata, 32'h0000_1004);
    tick();
    cmp("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    cmp("t1_rsp_data", rsp_data, 32'h100);
    cmp("t1_rsp_rd", 32'(rsp_rd), 32'd7);

    // CSRRS mstatus with rs1 = x0: read only
    wait_idle();
    send(3'b010, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd3);
    cmp("t2_c1_wr_en", 32'(csr_wr_en), 32'd0);
    tick();
    cmp("t2_c2_wr_en", 32'(csr_wr_en), 32'd0);
    cmp("t2_c2_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    cmp("t2_c3_wr_en", 32'(csr_wr_en), 32'd0);
    cmp("t2_c3_rsp_valid", 32'(rsp_valid), 32'd1);
    cmp("t2_rsp_data", rsp_data, 32'h0000_1888);

    // CSRRCI mip zimm = 8
    wait_idle();
    send(3'b111, 12'h344, 5'h08, 32'hDEAD_BEEF, 5'd9);
    tick(); tick();
    cmp("t3_wr_en", 32'(csr_wr_en), 32'd1);
    cmp("t3_wrdata", csr_wrdata, 32'h80);
    tick();
    cmp("t3_rsp_data", rsp_data, 32'h88);

    // Three freeze cycles in RD delay everything by three
    wait_idle();
    freeze = 1'b1;
    send(3'b001, 12'h340, 5'd1, 32'h5555_5555, 5'd4);
    tick(); tick(); tick();
    freeze = 1'b0;
    tick(); tick();
    cmp("t4_c6_wr_en", 32'(csr_wr_en), 32'd1);
    cmp("t4_c6_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    cmp("t4_c7_rsp_valid", 32'(rsp_valid), 32'd1);
    cmp("t4_rsp_data", rsp_data, 32'h0000_ABCD);

    // Flush in CAP aborts silently
    wait_idle();
    send(3'b001, 12'h305, 5'd2, 32'h77, 5'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cmp("t5_req_ready", 32'(req_ready), 32'd1);
    cmp("t5_wr_en", 32'(csr_wr_en), 32'd0);
    cmp("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("t5_quiet_rsp", 32'(rsp_valid), 32'd0);
      cmp("t5_quiet_wr", 32'(csr_wr_en), 32'd0);
    end

    // Illegal funct3 = 100
    wait_idle();
    send(3'b100, 12'h300, 5'd3, 32'h1, 5'd6);
    cmp("t6_rsp_valid", 32'(rsp_valid), 32'd1);
    cmp("t6_rsp_illegal", 32'(rsp_illegal), 32'd1);
    cmp("t6_rsp_data", rsp_data, 32'd0);

    // CSRRW to read-only mhartid
    wait_idle();
    send(3'b001, 12'hF14, 5'd1, 32'h0000_FFFF, 5'd2);
`ifdef CSR_RO_TRAP_EN
    cmp("t7_rsp_valid", 32'(rsp_valid), 32'd1);
    cmp("t7_rsp_illegal", 32'(rsp_illegal), 32'd1);
    cmp("t7_rsp_data", rsp_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cmp("t7_no_wr", 32'(csr_wr_en), 32'd0);
      tick();
    end
`else
    tick(); tick();
    cmp("t7_wr_en", 32'(csr_wr_en), 32'd1);
    cmp("t7_adr_wr", 32'(csr_adr_wr), 32'hF14);
    tick();
    cmp("t7_rsp_valid", 32'(rsp_valid), 32'd1);
    cmp("t7_rsp_illegal", 32'(rsp_illegal), 32'd0);
    cmp("t7_rsp_data", rsp_data, 32'd0);
`endif

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 299) == 0);
      req_valid   = ($urandom_range(0, 2) != 0);
      req_funct3  = 3'($urandom);
      req_csr     = addr_sel(int'($urandom_range(0, 5)));
      req_rs1_idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      req_rs1_val = $urandom;
      req_rd      = 5'($urandom);
      freeze      = ($urandom_range(0, 9) < 3);
      flush       = ($urandom_range(0, 15) == 0);
      rsp_ready   = ($urandom_range(0, 9) < 6);
    end
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    flush     = 1'b0;
    freeze    = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
